mem_port_arbiter: RTL

Two-master, one-slave arbiter that shares a single unified memory port between the CPU's instruction-fetch interface and its data load/store interface. It sits between the control unit's fetch and data handshakes and the memory. Both sides use the req/gnt/r_valid protocol, and the arbiter adds no cycles to the request path. It permits exactly one outstanding memory transaction and uses round-robin arbitration with a grant lock.

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between the instruction-fetch master and the data
// load/store master. Both sides speak req/gnt/r_valid. The request and
// response paths are purely combinational, so the arbiter adds no latency.
// Only one memory transaction may be outstanding at a time. Arbitration is
// round-robin. A stalled winner keeps the port through a grant lock until it
// is accepted.
//
// Ports:
//   CLK, RES_N         clock (rising edge), asynchronous active-low reset
//   instr_req/addr     fetch request, held until instr_gnt
//   instr_gnt          fetch request accepted this cycle
//   instr_r_valid      fetch response valid, qualifies instr_rdata
//   instr_rdata        fetch read data (always mirrors mem_rdata)
//   data_req/addr/...  load/store request (write_enable, wdata), held until gnt
//   data_gnt           data request accepted this cycle
//   data_r_valid       data response valid (reads and writes)
//   data_rdata         load read data (always mirrors mem_rdata)
//   mem_req/addr/we/wdata  request to memory; all zero when mem_req is low
//   mem_gnt            memory accepted mem_req
//   mem_r_valid/rdata  memory response
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RES_N,
  // instruction fetch master
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              instr_gnt,
  output logic              instr_r_valid,
  output logic [DATA_W-1:0] instr_rdata,
  // data load/store master
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              data_write_enable,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_r_valid,
  output logic [DATA_W-1:0] data_rdata,
  // memory slave
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_r_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } state_t;

  // Master encoding used by owner / last_grant / lock_sel / winner.
  localparam logic SEL_INSTR = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

  state_t state_reg, state_next;
  logic   owner_reg, owner_next;
  logic   last_grant_reg, last_grant_next;
  logic   lock_valid_reg, lock_valid_next;
  logic   lock_sel_reg, lock_sel_next;

  logic   winner;
  logic   winner_req;
  logic   req_out;

  // Read data is never gated; only r_valid qualifies it.
  assign instr_rdata = mem_rdata;
  assign data_rdata  = mem_rdata;

  // Winner selection. A lock pins the selection to a stalled master so the
  // request presented to memory cannot change underneath it.
  always_comb begin
    winner = SEL_INSTR;
    if (lock_valid_reg) begin
      winner = lock_sel_reg;
    end else if (instr_req && data_req) begin
      winner = ~last_grant_reg;
    end else if (data_req) begin
      winner = SEL_DATA;
    end
  end

  assign winner_req = (winner == SEL_DATA) ? data_req : instr_req;

  // Outputs are forced low while reset is held, even though the inputs may
  // still be requesting, hence the RES_N term.
  assign req_out = RES_N && (state_reg == IDLE) && winner_req;

  // State register
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_reg      <= IDLE;
      owner_reg      <= SEL_INSTR;
      last_grant_reg <= SEL_DATA;   // instr wins the first tie
      lock_valid_reg <= 1'b0;
      lock_sel_reg   <= SEL_INSTR;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      lock_valid_reg <= lock_valid_next;
      lock_sel_reg   <= lock_sel_next;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    lock_valid_next = lock_valid_reg;
    lock_sel_next   = lock_sel_reg;

    mem_req       = 1'b0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    instr_gnt     = 1'b0;
    data_gnt      = 1'b0;
    instr_r_valid = 1'b0;
    data_r_valid  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_out) begin
          mem_req = 1'b1;
          if (winner == SEL_DATA) begin
            mem_addr  = data_addr;
            mem_we    = data_write_enable;
            mem_wdata = data_wdata;
            data_gnt  = mem_gnt;
          end else begin
            mem_addr  = instr_addr;
            instr_gnt = mem_gnt;
          end

          if (mem_gnt) begin
            owner_next      = winner;
            last_grant_next = winner;
            lock_valid_next = 1'b0;
            state_next      = WAIT_RESP;
          end else begin
            lock_valid_next = 1'b1;
            lock_sel_next   = winner;
          end
        end else if (lock_valid_reg) begin
          // Locked master withdrew its request without a grant: release it.
          lock_valid_next = 1'b0;
        end
        // mem_r_valid arriving here is a stray response and is dropped.
      end

      WAIT_RESP: begin
        if (mem_r_valid && RES_N) begin
          if (owner_reg == SEL_DATA) begin
            data_r_valid = 1'b1;
          end else begin
            instr_r_valid = 1'b1;
          end
          // Return to IDLE; the next grant can only happen next cycle.
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
